drum_voice_mixer: RTL and testbench
===================================

Name: drum_voice_mixer

Overview:
Downstream audio stage of the drum machine. Consumes the per-step instrument bits (ins1..ins4) and the beat strobe from the tempo generator. It turns each active instrument into a decaying tone voice, mixes the four voices, and emits a signed 16-bit sample at the audio sample rate for the codec interface. It also drives per-voice activity flags for the LEDs.

Parameters:
CLK_HZ, 50000000, system clock frequency
SAMPLE_HZ, 48000, output sample rate; divider DIV = CLK_HZ/SAMPLE_HZ (integer division, 1041 at defaults)
DECAY_DIV, 64, sample ticks between envelope decrements (>=1)
HALF_PERIOD_0, 24, voice 0 tone half-period in sample ticks (>=1)
HALF_PERIOD_1, 48, voice 1 half-period
HALF_PERIOD_2, 6, voice 2 half-period
HALF_PERIOD_3, 12, voice 3 half-period

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-low reset (KEY[1])
step  input  1  one-cycle beat strobe from tempo generator
play  input  1  high while the sequencer is in play state
ins  input  4  current-step instrument bits, ins[i] = instrument i+1
sample  output  16  signed two's-complement mixed sample
sample_valid  output  1  one-cycle pulse; sample is updated on that cycle
voice_active  output  4  bit i high while voice i envelope is nonzero

Behaviour:
- Reset (asynchronous, active-low) clears all state and outputs immediately: divider, tone counters, tone phases, envelopes, sample, sample_valid and voice_active all go to 0.
- Sample tick: the divider counts 0..DIV-1. The tick is high in the cycle where count == DIV-1, then the count wraps to 0. Period is exactly DIV cycles.
- Per voice i: 8-bit amplitude amp_i, tone counter tc_i, phase bit ph_i, and a decay counter shared by all voices.
- Trigger: in any cycle with step & play & ins[i], set amp_i = 255, tc_i = 0, ph_i = 1.
  - A trigger has priority over the decay and tone updates of the same cycle.
  - If play = 0, step is ignored and envelopes keep decaying.
- On each tick, with no trigger on voice i:
  - tc_i increments. When tc_i == HALF_PERIOD_i-1 it wraps to 0 and ph_i toggles.
  - When the decay counter reaches DECAY_DIV-1, the decay counter wraps and every amp_i decrements by 1, saturating at 0.
- Mixing on a tick uses the pre-update register values:
  - v_i = ph_i ? +amp_i : -amp_i, as a 9-bit signed value.
  - sum = v_0 + v_1 + v_2 + v_3, as 11-bit signed (range ±1020).
  - sample = sum sign-extended and shifted left by 5 (max ±32640, no overflow).
- Latency: sample and sample_valid are registered, so both appear in the cycle after the tick.
  - sample_valid is high for exactly 1 cycle.
  - sample holds its value until the next pulse.
- voice_active[i] = (amp_i != 0), registered; it follows amp_i with 1-cycle latency.
- A retrigger while a voice is still sounding restarts that voice cleanly (amp 255, phase high).

Optional Feature:
NOISE_VOICE_EN
- Defined: voice 3 ignores the tone counter and takes its sign from a 16-bit Fibonacci LFSR.
  - Taps: x^16+x^14+x^13+x^11+1. Seed: 16'hACE1 on reset.
  - The LFSR advances once per sample tick and is not reset by a trigger.
  - v_3 = lfsr[0] ? +amp_3 : -amp_3.
- Undefined: voice 3 is a square wave like the others; no LFSR logic is present.

Test Plan:
- Bench parameters: CLK_HZ=100, SAMPLE_HZ=10 (DIV=10), DECAY_DIV=1, all HALF_PERIOD=2.
- Reset: hold reset low -> sample=0, sample_valid=0, voice_active=0. Release reset and idle 100 cycles -> 10 sample_valid pulses, exactly 10 cycles apart, all with sample=0.
- Single voice: play=1, step pulse with ins=4'b0001 -> next five samples are 8160, 8128, -8096, -8064, 8032. voice_active=0001.
- Decay to silence: after the trigger, wait 255 ticks -> voice_active[0]=0 and sample=0 thereafter; amp saturates at 0 with no wrap.
- Full mix: step with ins=4'b1111 -> first sample = 32640. Then pulse reset low mid-run -> all outputs 0 asynchronously, before the next clk edge.
- Play gating and priority:
  - play=0, step with ins=1111 -> samples stay 0.
  - play=1, step coinciding with a tick on a decaying voice (amp 100) -> amp reloads to 255, and the next-but-one sample magnitude = 8160.
- NOISE_VOICE_EN defined: trigger voice 3 only -> sign of each sample matches a reference LFSR model (seed ACE1) for 64 ticks; magnitudes follow 255, 254, 253...

Source files
------------

// File: rtl/drum_voice_mixer.sv
// Four-voice decaying square-wave drum mixer producing a signed 16-bit sample per audio tick.
// Optional NOISE_VOICE_EN: voice 3 takes its sign from a 16-bit LFSR instead of its tone phase.
module drum_voice_mixer #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned SAMPLE_HZ     = 48000,
    parameter int unsigned DECAY_DIV     = 64,
    parameter int unsigned HALF_PERIOD_0 = 24,
    parameter int unsigned HALF_PERIOD_1 = 48,
    parameter int unsigned HALF_PERIOD_2 = 6,
    parameter int unsigned HALF_PERIOD_3 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        play,
    input  logic [3:0]  ins,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [3:0]  voice_active
);

    localparam int unsigned DIV    = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int unsigned HP_A   = (HALF_PERIOD_0 > HALF_PERIOD_1) ? HALF_PERIOD_0 : HALF_PERIOD_1;
    localparam int unsigned HP_B   = (HALF_PERIOD_2 > HALF_PERIOD_3) ? HALF_PERIOD_2 : HALF_PERIOD_3;
    localparam int unsigned HP_MAX = (HP_A > HP_B) ? HP_A : HP_B;
    localparam int unsigned TC_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

    function automatic logic [TC_W-1:0] tc_last(input int unsigned idx);
        case (idx)
            0:       return TC_W'(HALF_PERIOD_0 - 1);
            1:       return TC_W'(HALF_PERIOD_1 - 1);
            2:       return TC_W'(HALF_PERIOD_2 - 1);
            default: return TC_W'(HALF_PERIOD_3 - 1);
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [DEC_W-1:0] dec_cnt;
    logic [7:0]       amp [4];
    logic [TC_W-1:0]  tc  [4];
    logic [3:0]       ph;
    logic [3:0]       voice_sign;
    logic             tick;
    logic             dec_wrap;
    logic [3:0]       trig;
    logic signed [8:0]  mix_v [4];
    logic signed [10:0] mix_sum;

    assign tick     = (div_cnt == DIV_W'(DIV - 1));
    assign dec_wrap = (dec_cnt == DEC_W'(DECAY_DIV - 1));
    assign trig     = ins & {4{step & play}};

`ifdef NOISE_VOICE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards bit 0
    assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign voice_sign = {lfsr[0], ph[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (tick) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign voice_sign = ph;
`endif

    // Mix always sees the register values before this tick's updates
    always_comb begin
        mix_sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mix_v[i] = voice_sign[i] ? $signed({1'b0, amp[i]}) : -$signed({1'b0, amp[i]});
            mix_sum  = mix_sum + {{2{mix_v[i][8]}}, mix_v[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            dec_cnt      <= '0;
            ph           <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            voice_active <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                amp[i] <= '0;
                tc[i]  <= '0;
            end
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + 1'b1;
            sample_valid <= tick;
            if (tick) begin
                sample  <= {mix_sum, 5'b0};
                dec_cnt <= dec_wrap ? '0 : dec_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                voice_active[i] <= (amp[i] != '0);
                if (trig[i]) begin
                    amp[i] <= 8'hFF;
                    tc[i]  <= '0;
                    ph[i]  <= 1'b1;
                end else if (tick) begin
                    if (tc[i] == tc_last(i)) begin
                        tc[i] <= '0;
                        ph[i] <= ~ph[i];
                    end else begin
                        tc[i] <= tc[i] + 1'b1;
                    end
                    if (dec_wrap && (amp[i] != '0)) begin
                        amp[i] <= amp[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Directed bench for drum_voice_mixer with DIV=10, DECAY_DIV=1 and all half-periods 2.
// Define NOISE_VOICE_EN for both bench and RTL to exercise the LFSR voice.
module tb_drum_voice_mixer;

    logic        clk;
    logic        reset;
    logic        step;
    logic        play;
    logic [3:0]  ins;
    logic [15:0] sample;
    logic        sample_valid;
    logic [3:0]  voice_active;

    int n_cmp = 0;
    int n_err = 0;

    drum_voice_mixer #(
        .CLK_HZ(100),
        .SAMPLE_HZ(10),
        .DECAY_DIV(1),
        .HALF_PERIOD_0(2),
        .HALF_PERIOD_1(2),
        .HALF_PERIOD_2(2),
        .HALF_PERIOD_3(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step(step),
        .play(play),
        .ins(ins),
        .sample(sample),
        .sample_valid(sample_valid),
        .voice_active(voice_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances to the negedge on which sample_valid is seen, bounded to 30 cycles
    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = sample_valid;
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s_timeout observed=0 expected=1", tag);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    endfunction

    function automatic int smp();
        return int'($signed(sample));
    endfunction

    int          last_c;
    int          n_pulse;
    int          exp_v;
    int          mag;
    logic [15:0] ref_lfsr;

    initial begin
        reset = 1'b0;
        step  = 1'b0;
        play  = 1'b0;
        ins   = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sample", smp(), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_active", int'(voice_active), 0);

        // Idle: 10 pulses, 10 cycles apart, all silent
        reset   = 1'b1;
        last_c  = 0;
        n_pulse = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                n_pulse++;
                chk("idle_gap", c - last_c, 10);
                chk("idle_sample", smp(), 0);
                last_c = c;
            end
        end
        chk("idle_pulses", n_pulse, 10);

        // Single voice 0 trigger, issued right after a tick (divider at 0)
        play = 1'b1;
        step = 1'b1;
        ins  = 4'b0001;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        wait_valid("v0_s1"); chk("v0_s1", smp(), 8160);
        wait_valid("v0_s2"); chk("v0_s2", smp(), 8128);
        wait_valid("v0_s3"); chk("v0_s3", smp(), -8096);
        wait_valid("v0_s4"); chk("v0_s4", smp(), -8064);
        wait_valid("v0_s5"); chk("v0_s5", smp(), 8032);
        chk("v0_active", int'(voice_active), 1);

        // Decay to silence: tick 255 carries amp 1 (negative phase)
        for (int k = 6; k <= 255; k++) wait_valid("decay");
        chk("decay_last", smp(), -32);
        chk("decay_active_lag", int'(voice_active), 1);
        @(negedge clk);
        chk("decay_active_off", int'(voice_active), 0);
        for (int k = 0; k < 3; k++) begin
            wait_valid("silent");
            chk("silent_sample", smp(), 0);
            chk("silent_active", int'(voice_active), 0);
        end

        // Full mix
        step = 1'b1;
        ins  = 4'b1111;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        wait_valid("mix");
`ifdef NOISE_VOICE_EN
        chk("mix_sample", int'(smp() == 32640 || smp() == 16320), 1);
`else
        chk("mix_sample", smp(), 32640);
`endif
        repeat (3) @(negedge clk);
        chk("mix_active", int'(voice_active), 15);

        // Asynchronous reset between clock edges
        #1 reset = 1'b0;
        #1;
        chk("arst_sample", smp(), 0);
        chk("arst_valid", int'(sample_valid), 0);
        chk("arst_active", int'(voice_active), 0);
        @(negedge clk);
        reset = 1'b1;

        // Play gating
        play = 1'b0;
        step = 1'b1;
        ins  = 4'b1111;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            wait_valid("gate");
            chk("gate_sample", smp(), 0);
            chk("gate_active", int'(voice_active), 0);
        end

        // Retrigger coinciding with a tick while amp is 100
        play = 1'b1;
        step = 1'b1;
        ins  = 4'b0001;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        for (int k = 0; k < 155; k++) wait_valid("pri_wait");
        repeat (9) @(negedge clk);
        step = 1'b1;
        ins  = 4'b0001;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        chk("pri_valid", int'(sample_valid), 1);
        chk("pri_pre", smp(), -3200);
        wait_valid("pri_post");
        chk("pri_post", smp(), 8160);

`ifdef NOISE_VOICE_EN
        // Noise voice: sign follows reference LFSR, magnitude decays by one per tick
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        ref_lfsr = 16'hACE1;
        wait_valid("nz_first");
        ref_lfsr = lfsr_next(ref_lfsr);
        step = 1'b1;
        ins  = 4'b1000;
        @(negedge clk);
        step = 1'b0;
        ins  = 4'b0000;
        for (int j = 0; j < 64; j++) begin
            wait_valid("nz");
            mag   = (255 - j) * 32;
            exp_v = ref_lfsr[0] ? mag : -mag;
            chk("nz_sample", smp(), exp_v);
            ref_lfsr = lfsr_next(ref_lfsr);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
